// File: rtl/radix8_booth_seq_mult_if.sv
// Operand/product handshake bundle for radix8_booth_seq_mult.
interface radix8_booth_seq_mult_if #(
  parameter int unsigned N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           signed_mode;
  logic           mod_sel;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;

  modport master (
    output in_valid, multiplicand, multiplier, signed_mode, mod_sel, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, signed_mode, mod_sel, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/radix8_booth_seq_mult.sv
// Sequential radix-8 Booth multiplier: one partial product per BUSY cycle.
// Optional mod 2^N-1 reduction of unsigned products is built when RADIX8_MOD_REDUCE_EN is defined.
module radix8_booth_seq_mult #(
  parameter int unsigned N = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  radix8_booth_seq_mult_if.slave bus
);

  localparam int unsigned G  = (N + 3) / 3;
  localparam int unsigned AW = 2 * N + 3;
  localparam int unsigned YW = 3 * G + 1;
  localparam int unsigned CW = $clog2(G + 1);
  localparam int unsigned PW = 2 * N;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
`ifdef RADIX8_MOD_REDUCE_EN
    S_REDUCE = 2'd3,
`endif
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;
  logic [AW-1:0]   xq_q;
  logic [YW-1:0]   yq_q;
  logic [CW-1:0]   cnt_q;
  logic            signed_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [PW-1:0]   product_q;

  logic [AW-1:0]   x_load;
  logic [YW-1:0]   y_load;
  logic [3:0]      digit;
  logic [2:0]      mag;
  logic            neg;
  logic [AW-1:0]   mult;
  logic [AW-1:0]   pp;

  // Multiplicand widened to accumulator width; multiplier widened to 3G bits plus the implicit bit -1.
  always_comb begin
    x_load = bus.signed_mode ? {{(AW-N){bus.multiplicand[N-1]}}, bus.multiplicand}
                             : {{(AW-N){1'b0}}, bus.multiplicand};
    y_load = bus.signed_mode ? {{(YW-1-N){bus.multiplier[N-1]}}, bus.multiplier, 1'b0}
                             : {{(YW-1-N){1'b0}}, bus.multiplier, 1'b0};
  end

  // Radix-8 recoding: digit = -4*b3 + 2*b2 + b1 + b0 over bits [3i+2:3i-1].
  always_comb begin
    digit = yq_q[3:0];
    neg   = digit[3];
    mag   = 3'd0;
    case (digit)
      4'b0000, 4'b1111: mag = 3'd0;
      4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = 3'd1;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = 3'd2;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = 3'd3;
      default: mag = 3'd4;
    endcase
    mult = '0;
    case (mag)
      3'd1:    mult = xq_q;
      3'd2:    mult = {xq_q[AW-2:0], 1'b0};
      3'd3:    mult = xq_q + {xq_q[AW-2:0], 1'b0};
      3'd4:    mult = {xq_q[AW-3:0], 2'b00};
      default: mult = '0;
    endcase
    pp    = neg ? (~mult + AW'(1)) : mult;
    acc_d = acc_q + pp;
  end

`ifdef RADIX8_MOD_REDUCE_EN
  logic          mod_q;
  logic [N:0]    red_sum;
  logic [N-1:0]  red_fold;
  logic [N-1:0]  red_res;

  // End-around-carry fold of the 2N-bit product; the all-ones residue aliases zero.
  always_comb begin
    red_sum  = {1'b0, acc_q[N-1:0]} + {1'b0, acc_q[PW-1:N]};
    red_fold = red_sum[N-1:0] + N'(red_sum[N]);
    red_res  = (&red_fold) ? '0 : red_fold;
  end
`else
  logic unused_mod_sel;
  assign unused_mod_sel = bus.mod_sel;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      xq_q        <= '0;
      yq_q        <= '0;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
`ifdef RADIX8_MOD_REDUCE_EN
      mod_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_q    <= S_BUSY;
            acc_q      <= '0;
            cnt_q      <= '0;
            xq_q       <= x_load;
            yq_q       <= y_load;
            signed_q   <= bus.signed_mode;
            in_ready_q <= 1'b0;
`ifdef RADIX8_MOD_REDUCE_EN
            mod_q      <= bus.mod_sel;
`endif
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          xq_q  <= {xq_q[AW-4:0], 3'b000};
          yq_q  <= {{3{yq_q[YW-1]}}, yq_q[YW-1:3]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(G - 1)) begin
`ifdef RADIX8_MOD_REDUCE_EN
            if (!signed_q && mod_q) begin
              state_q <= S_REDUCE;
            end else
`endif
            begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              product_q   <= acc_d[PW-1:0];
            end
          end
        end
`ifdef RADIX8_MOD_REDUCE_EN
        S_REDUCE: begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
          product_q   <= PW'(red_res);
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // signed_q only steers the optional reduction.
  logic unused_signed;
  assign unused_signed = signed_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_radix8_booth_seq_mult.sv
// Self-checking bench for radix8_booth_seq_mult (N=8) against an arithmetic reference model.
module tb_radix8_booth_seq_mult;

  localparam int unsigned N = 8;
  localparam int G = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  radix8_booth_seq_mult_if #(.N(N)) bus ();

  radix8_booth_seq_mult #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic reduce_active(input logic s, input logic m);
`ifdef RADIX8_MOD_REDUCE_EN
    return !s && m;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] ref_product(input logic [7:0] x, input logic [7:0] y,
                                              input logic s, input logic m);
    longint r;
    if (s) r = longint'($signed(x)) * longint'($signed(y));
    else   r = longint'(x) * longint'(y);
    if (reduce_active(s, m)) r = r % 255;
    return 16'(r);
  endfunction

  function automatic int ref_latency(input logic s, input logic m);
    return reduce_active(s, m) ? G + 1 : G;
  endfunction

  // Handshake one operation, wait for the result, optionally stall, then consume it.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s, input logic m,
                        input int stall, output logic [15:0] p, output int lat);
    int n;
    bus.multiplicand = x;
    bus.multiplier   = y;
    bus.signed_mode  = s;
    bus.mod_sel      = m;
    bus.in_valid     = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) begin
      vectors++; miscompares++;
      $display("FAIL run_op_timeout x=%0h y=%0h out_valid never rose", x, y);
    end
    p = bus.product;
    repeat (stall) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.multiplicand = '0; bus.multiplier = '0; bus.signed_mode = 1'b0; bus.mod_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    vectors++;
    if (bus.product !== 16'h0000) begin miscompares++; $display("FAIL reset_product got=%h exp=0000", bus.product); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [7:0]  xs [7] = '{8'h80, 8'h07, 8'hFF, 8'd200, 8'hFF, 8'd200, 8'h00};
    logic [7:0]  ys [7] = '{8'h80, 8'hFD, 8'hFF, 8'd100, 8'hFF, 8'd100, 8'h5A};
    logic        ss [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ms [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] p;
    logic [15:0] exp_p;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      run_op(xs[i], ys[i], ss[i], ms[i], 0, p, lat);
      exp_p = ref_product(xs[i], ys[i], ss[i], ms[i]);
      vectors++;
      if (p !== exp_p) begin
        miscompares++;
        $display("FAIL directed_product[%0d] x=%h y=%h s=%b m=%b got=%h exp=%h", i, xs[i], ys[i], ss[i], ms[i], p, exp_p);
      end
      vectors++;
      if (lat !== ref_latency(ss[i], ms[i])) begin
        miscompares++;
        $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, ref_latency(ss[i], ms[i]));
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_p;
    int n;
    exp_p = ref_product(8'h5A, 8'hC3, 1'b1, 1'b0);
    bus.multiplicand = 8'h5A; bus.multiplier = 8'hC3; bus.signed_mode = 1'b1; bus.mod_sel = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.multiplicand = 8'hFF; bus.multiplier = 8'h7F; bus.signed_mode = 1'b0; bus.mod_sel = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=1", c, bus.out_valid); end
      vectors++;
      if (bus.product !== exp_p) begin miscompares++; $display("FAIL stall_product cyc=%0d got=%h exp=%h", c, bus.product, exp_p); end
      vectors++;
      if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release_out_valid got=%b exp=0", bus.out_valid); end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_reset_midop();
    logic [15:0] p;
    int lat;
    bus.multiplicand = 8'h33; bus.multiplier = 8'h44; bus.signed_mode = 1'b0; bus.mod_sel = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_out_valid got=%b exp=0", bus.out_valid); end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL midreset_idle cyc=%0d out_valid=%b in_ready=%b exp 0/1", c, bus.out_valid, bus.in_ready);
      end
    end
    run_op(8'd12, 8'd12, 1'b0, 1'b0, 0, p, lat);
    vectors++;
    if (p !== 16'h0090) begin miscompares++; $display("FAIL midreset_next_product got=%h exp=0090", p); end
  endtask

  task automatic test_back_to_back();
    int t_last;
    int t_now;
    int n;
    logic [15:0] exp_p;
    exp_p = ref_product(8'h9C, 8'h27, 1'b1, 1'b0);
    bus.multiplicand = 8'h9C; bus.multiplier = 8'h27; bus.signed_mode = 1'b1; bus.mod_sel = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    t_last = -1; n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        t_now = cyc;
        vectors++;
        if (bus.product !== exp_p) begin miscompares++; $display("FAIL b2b_product got=%h exp=%h", bus.product, exp_p); end
        if (t_last >= 0) begin
          vectors++;
          if (t_now - t_last !== G + 2) begin
            miscompares++; $display("FAIL b2b_period got=%0d exp=%0d", t_now - t_last, G + 2);
          end
        end
        t_last = t_now; n++;
      end
    end
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL b2b_count got=%0d exp=4", n); end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 40) begin @(posedge clk); #1; n++; end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0]  x;
    logic [7:0]  y;
    logic        s;
    logic        m;
    logic [15:0] p;
    logic [15:0] exp_p;
    int          lat;
    for (int i = 0; i < 10000; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      s = (i < 5000) ? 1'b1 : 1'b0;
      m = 1'($urandom);
      run_op(x, y, s, m, ($urandom_range(0, 7) == 0) ? 1 : 0, p, lat);
      exp_p = ref_product(x, y, s, m);
      vectors++;
      if (p !== exp_p || lat !== ref_latency(s, m)) begin
        miscompares++;
        $display("FAIL random[%0d] x=%h y=%h s=%b m=%b got=%h/%0d exp=%h/%0d",
                 i, x, y, s, m, p, lat, exp_p, ref_latency(s, m));
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
